// File: rtl/reflet_debug_bridge_pkg.sv
// Shared constants and state encoding for the byte-stream debug bridge.
package reflet_debug_bridge_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        BUS_WR,
        BUS_RD_ADDR,
        BUS_RD_CAP,
        SEND
    } state_t;

endpackage

// File: rtl/reflet_debug_bridge.sv
// Turns framed 'W'/'R' byte commands into single peripheral bus cycles and
// streams the acknowledgement or read data back out, LSB first.
module reflet_debug_bridge
    import reflet_debug_bridge_pkg::*;
#(
    parameter int wordsize  = 16,
    parameter int addr_size = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 enable,
    output logic [addr_size-1:0] addr,
    output logic                 write_en,
    output logic [wordsize-1:0]  data_out,
    input  logic [wordsize-1:0]  data_in
);

    localparam int AB   = addr_size / 8;
    localparam int WB   = wordsize / 8;
    localparam int MAXB = (AB > WB) ? AB : WB;
    localparam int CW   = $clog2(MAXB + 1);

    state_t               state, state_next;
    logic [7:0]           opcode;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        send_last;
    logic [addr_size-1:0] addr_sr;
    logic [wordsize-1:0]  data_sr;
    logic [addr_size-1:0] addr_reg;
    logic [wordsize-1:0]  dout_reg;
    logic [addr_size-1:0] addr_shift;
    logic [wordsize-1:0]  data_shift;
    logic                 rx_hs;
    logic                 tx_hs;
    logic                 addr_last;
    logic                 data_last;

    // Incoming bytes enter at the top so the first (least significant) byte ends up at the bottom.
    assign addr_shift = (addr_sr >> 8) | (addr_size'(rx_data) << (addr_size - 8));
    assign data_shift = (data_sr >> 8) | (wordsize'(rx_data) << (wordsize - 8));
    assign rx_hs      = rx_valid && rx_ready;
    assign tx_hs      = tx_valid && tx_ready;
    assign addr_last  = (cnt == CW'(AB - 1));
    assign data_last  = (cnt == CW'(WB - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rx_hs) begin
                    state_next = (rx_data == OP_WRITE || rx_data == OP_READ) ? GET_ADDR : SEND;
                end
            end
            GET_ADDR: begin
                if (rx_hs && addr_last) begin
                    state_next = (opcode == OP_WRITE) ? GET_DATA : BUS_RD_ADDR;
                end
            end
            GET_DATA: begin
                if (rx_hs && data_last) begin
                    state_next = BUS_WR;
                end
            end
            BUS_WR:      state_next = SEND;
            BUS_RD_ADDR: state_next = BUS_RD_CAP;
            BUS_RD_CAP:  state_next = SEND;
            SEND: begin
                if (tx_hs && cnt == send_last) begin
                    state_next = IDLE;
                end
            end
            default:     state_next = IDLE;
        endcase
    end

    always_comb begin
        rx_ready = (state == IDLE) || (state == GET_ADDR) || (state == GET_DATA);
        tx_valid = (state == SEND);
        tx_data  = (state == SEND) ? data_sr[7:0] : 8'h00;
        enable   = (state == BUS_WR) || (state == BUS_RD_ADDR) || (state == BUS_RD_CAP);
        write_en = (state == BUS_WR);
        addr     = addr_reg;
        data_out = dout_reg;
    end

    // Bus-facing addr/data_out are loaded only as a bus cycle begins so they hold between cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opcode    <= '0;
            cnt       <= '0;
            send_last <= '0;
            addr_sr   <= '0;
            data_sr   <= '0;
            addr_reg  <= '0;
            dout_reg  <= '0;
        end else begin
            if (state != state_next) begin
                cnt <= '0;
            end else if ((rx_hs && state != IDLE) || tx_hs) begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rx_hs) begin
                        opcode <= rx_data;
                        if (rx_data != OP_WRITE && rx_data != OP_READ) begin
                            data_sr   <= wordsize'(RSP_ERR);
                            send_last <= '0;
                        end
                    end
                end
                GET_ADDR: begin
                    if (rx_hs) begin
                        addr_sr <= addr_shift;
                        if (addr_last && opcode == OP_READ) begin
                            addr_reg <= addr_shift;
                        end
                    end
                end
                GET_DATA: begin
                    if (rx_hs) begin
                        data_sr <= data_shift;
                        if (data_last) begin
                            dout_reg <= data_shift;
                            addr_reg <= addr_sr;
                        end
                    end
                end
                BUS_WR: begin
                    data_sr   <= wordsize'(RSP_ACK);
                    send_last <= '0;
                end
                BUS_RD_CAP: begin
                    data_sr   <= data_in;
                    send_last <= CW'(WB - 1);
                end
                SEND: begin
                    if (tx_hs) begin
                        data_sr <= data_sr >> 8;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_debug_bridge.sv
// Scoreboard bench for reflet_debug_bridge: stimulus queues expected tx bytes and
// bus writes, a negedge monitor pops and compares them as the DUT presents them.
module tb_reflet_debug_bridge;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        enable;
    logic [15:0] addr;
    logic        write_en;
    logic [15:0] data_out;
    logic [15:0] data_in;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] wr_q[$];
    logic [7:0]  exp_tx;
    logic [31:0] exp_wr;

    reflet_debug_bridge #(.wordsize(16), .addr_size(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .enable   (enable),
        .addr     (addr),
        .write_en (write_en),
        .data_out (data_out),
        .data_in  (data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rd_model(input logic [15:0] a);
        if (a == 16'h0003) return 16'hABCD;
        return {a[7:0] ^ 8'h5A, 8'h77};
    endfunction

    // Registered peripheral responder: data appears the cycle after a read address.
    always @(posedge clk or negedge reset) begin
        if (!reset) data_in <= '0;
        else if (enable && !write_en) data_in <= rd_model(addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor samples just after the negedge, when inputs for the next posedge are settled.
    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_tx: got %h expected no byte", tx_data);
                end else begin
                    exp_tx = tx_q.pop_front();
                    check("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx});
                end
            end
            if (enable && write_en) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_bus_write: got addr %h data %h expected none", addr, data_out);
                end else begin
                    exp_wr = wr_q.pop_front();
                    check("bus_write", {addr, data_out}, exp_wr);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL rx_timeout: got rx_ready 0 expected 1");
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic gap();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((tx_q.size() != 0 || wr_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", tx_q.size() + wr_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_rx_ready"}, {31'h0, rx_ready}, 32'h1);
        check({tag, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
        check({tag, "_tx_data"},  {24'h0, tx_data},  32'h0);
        check({tag, "_enable"},   {31'h0, enable},   32'h0);
        check({tag, "_write_en"}, {31'h0, write_en}, 32'h0);
        check({tag, "_addr"},     {16'h0, addr},     32'h0);
        check({tag, "_data_out"}, {16'h0, data_out}, 32'h0);
    endtask

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        reset    = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        #1;
        checkOutput("reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        $display("[TB] write frame");
        wr_q.push_back({16'h0002, 16'h0007});
        tx_q.push_back(8'h4B);
        applyStimulus(8'h57);
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'h07);
        applyStimulus(8'h00);
        @(negedge clk);
        check("wr_lat_enable", {31'h0, enable},   32'h1);
        check("wr_lat_we",     {31'h0, write_en}, 32'h1);
        @(negedge clk);
        check("wr_lat_txv",    {31'h0, tx_valid}, 32'h1);
        check("wr_lat_txd",    {24'h0, tx_data},  32'h4B);
        check("wr_lat_enoff",  {31'h0, enable},   32'h0);
        drain();
        check("hold_addr",     {16'h0, addr},     32'h0002);
        check("hold_data",     {16'h0, data_out}, 32'h0007);

        $display("[TB] read frame");
        tx_q.push_back(8'hCD);
        tx_q.push_back(8'hAB);
        applyStimulus(8'h52);
        applyStimulus(8'h03);
        applyStimulus(8'h00);
        @(negedge clk);
        check("rd_c1_enable", {31'h0, enable},   32'h1);
        check("rd_c1_we",     {31'h0, write_en}, 32'h0);
        check("rd_c1_addr",   {16'h0, addr},     32'h0003);
        @(negedge clk);
        check("rd_c2_enable", {31'h0, enable},   32'h1);
        check("rd_c2_we",     {31'h0, write_en}, 32'h0);
        @(negedge clk);
        check("rd_c3_txv",    {31'h0, tx_valid}, 32'h1);
        check("rd_c3_txd",    {24'h0, tx_data},  32'hCD);
        drain();
        check("rd_hold_data", {16'h0, data_out}, 32'h0007);

        $display("[TB] bad opcode");
        tx_q.push_back(8'h3F);
        applyStimulus(8'h00);
        @(negedge clk);
        check("bad_enable", {31'h0, enable}, 32'h0);
        check("bad_txd",    {24'h0, tx_data}, 32'h3F);
        drain();
        tx_q.push_back(8'hCD);
        tx_q.push_back(8'hAB);
        applyStimulus(8'h52);
        applyStimulus(8'h03);
        applyStimulus(8'h00);
        drain();

        $display("[TB] backpressure");
        tx_ready = 1'b0;
        tx_q.push_back(8'hCD);
        tx_q.push_back(8'hAB);
        applyStimulus(8'h52);
        applyStimulus(8'h03);
        applyStimulus(8'h00);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_txv", {31'h0, tx_valid}, 32'h1);
            check("bp_txd", {24'h0, tx_data},  32'hCD);
            @(negedge clk);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        check("bp_next_txv", {31'h0, tx_valid}, 32'h1);
        check("bp_next_txd", {24'h0, tx_data},  32'hAB);
        drain();

        $display("[TB] gapped write");
        wr_q.push_back({16'h0010, 16'h1234});
        tx_q.push_back(8'h4B);
        applyStimulus(8'h57);
        gap();
        applyStimulus(8'h10);
        gap();
        applyStimulus(8'h00);
        gap();
        applyStimulus(8'h34);
        gap();
        applyStimulus(8'h12);
        drain();

        $display("[TB] reset mid-frame");
        applyStimulus(8'h57);
        applyStimulus(8'h02);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("midreset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_txv", {31'h0, tx_valid}, 32'h0);
        check("post_reset_en",  {31'h0, enable},   32'h0);
        tx_q.push_back(8'h77);
        tx_q.push_back(8'h5F);
        applyStimulus(8'h52);
        applyStimulus(8'h05);
        applyStimulus(8'h00);
        drain();

        check("final_tx_q", tx_q.size(), 32'h0);
        check("final_wr_q", wr_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
